noc_processor_tx: RTL and testbench

- Processor-side transmitter for the 2x2 mesh. It is the initiating end of the `pN_configure` / `processor_ready_signals[N]` interface.
- Accepts send requests (destination plus data byte) from a local processor and buffers them in a small FIFO.
- Drives the 11-bit configure word into the mesh, holds it until the mesh signals ready, then releases it and enforces an idle gap.
- One instance per processor port (p0..p3).

---
 rtl/noc_processor_tx_pkg.sv | 33 +++
 rtl/noc_tx_fifo.sv | 60 ++++++
 rtl/noc_processor_tx.sv | 127 ++++++++++++
 tb/tb_noc_processor_tx.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_processor_tx_pkg.sv
// Shared definitions for the NoC processor-side transmitter: configure-word
// layout, FSM encodings and the buffered request record.
package noc_processor_tx_pkg;

  localparam int CFG_W         = 11;
  localparam int DATA_W        = 8;
  localparam int DEST_W        = 2;
  localparam int REQ_W         = DATA_W + DEST_W;
  localparam int RX_DATA_W     = 9;
  localparam int CFG_VALID_BIT = 0;
  localparam int CFG_DEST_LSB  = 1;
  localparam int CFG_DATA_LSB  = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } req_t;

  // Packs a buffered request into the word driven onto the mesh.
  function automatic logic [CFG_W-1:0] make_cfg(input req_t r);
    logic [CFG_W-1:0] w;
    w = '0;
    w[CFG_DATA_LSB +: DATA_W] = r.data;
    w[CFG_DEST_LSB +: DEST_W] = r.dest;
    w[CFG_VALID_BIT]          = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/noc_tx_fifo.sv
// Request buffer for the transmitter: power-of-two depth, wrapping pointers,
// registered push-permission flag that stays low while in reset.
module noc_tx_fifo
  import noc_processor_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  req_t wr_data,
  output req_t rd_data,
  output logic empty,
  output logic can_push
);

  localparam int AW = $clog2(DEPTH);

  req_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic [AW:0]    count_next;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: combinational blocks use blocking '=' and give every output a
  // default first, so no latch is inferred; clocked blocks use '<=' only.
  always_comb begin
    count_next = count;
    if (do_push) count_next = count_next + 1'b1;
    if (do_pop)  count_next = count_next - 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      can_push <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      can_push <= (count_next != (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_processor_tx.sv
// Processor-side transmitter for the 2x2 mesh: buffers send requests and
// drives one configure word at a time. Define NOC_TX_TIMEOUT_EN to abandon
// transfers the mesh never accepts.
module noc_processor_tx
  import noc_processor_tx_pkg::*;
#(
  parameter int SRC_ID         = 0,
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_dest,
  input  logic [7:0]  req_data,
  input  logic        processor_ready,
  output logic [10:0] configure,
  output logic        busy,
  output logic        sent_pulse,
  output logic        drop_pulse,
  output logic [1:0]  src_id_o
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("noc_processor_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  if (GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1 || SRC_ID < 0 || SRC_ID > 3) begin : g_bad_param
    $error("noc_processor_tx: GAP_CYCLES/TIMEOUT_CYCLES/SRC_ID out of range");
  end

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  logic [1:0]    state;
  logic [GW-1:0] gap_cnt;
  logic          fifo_empty;
  logic          fifo_pop;
  req_t          fifo_head;
  req_t          fifo_in;
  logic          timeout_hit;

  assign fifo_in  = '{data: req_data, dest: req_dest};
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
  assign busy     = !fifo_empty || (state != ST_IDLE);
  assign src_id_o = 2'(SRC_ID);

  noc_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (req_valid && req_ready),
    .pop      (fifo_pop),
    .wr_data  (fifo_in),
    .rd_data  (fifo_head),
    .empty    (fifo_empty),
    .can_push (req_ready)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      configure  <= '0;
      sent_pulse <= 1'b0;
    end else begin
      sent_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            configure <= make_cfg(fifo_head);
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // Acceptance takes priority over an expiring timeout.
          if (processor_ready) begin
            configure  <= '0;
            sent_pulse <= 1'b1;
            gap_cnt    <= GAP_LOAD;
            state      <= ST_RELEASE;
          end else if (timeout_hit) begin
            configure <= '0;
            gap_cnt   <= GAP_LOAD;
            state     <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // A mesh that keeps ready high holds us here so transfers never overlap.
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
          else if (!processor_ready) state <= ST_IDLE;
        end
        default: begin
          configure <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NOC_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] drive_cnt;
  logic          drop_q;

  assign timeout_hit = (drive_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign drop_pulse  = drop_q;

  // Counts edges spent in DRIVE; sits at zero in every other state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drive_cnt <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q    <= (state == ST_DRIVE) && !processor_ready && timeout_hit;
      drive_cnt <= (state == ST_DRIVE) ? drive_cnt + 1'b1 : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign drop_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_noc_processor_tx.sv
// Self-checking bench for noc_processor_tx: directed scenarios plus random
// traffic, checked every cycle against a queue-based transaction model.
module tb_noc_processor_tx;

`ifdef NOC_TX_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_ON = 1'b1;
`else
  localparam int TO    = 64;
  localparam bit TO_ON = 1'b0;
`endif
  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_dest;
  logic [7:0]  req_data;
  logic        processor_ready;
  logic [10:0] configure;
  logic        busy;
  logic        sent_pulse;
  logic        drop_pulse;
  logic [1:0]  src_id_o;

  int n_checks = 0;
  int n_errors = 0;
  int sent_cnt = 0;
  int drop_cnt = 0;

  noc_processor_tx #(
    .SRC_ID         (0),
    .FIFO_DEPTH     (DEPTH),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_dest        (req_dest),
    .req_data        (req_data),
    .processor_ready (processor_ready),
    .configure       (configure),
    .busy            (busy),
    .sent_pulse      (sent_pulse),
    .drop_pulse      (drop_pulse),
    .src_id_o        (src_id_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic [1:0] t);
    return 11'(d) * 11'd8 + 11'(t) * 11'd2 + 11'd1;
  endfunction

  // Inputs change just after the falling edge, so the monitor (on the same
  // falling edge) still sees the values the preceding rising edge sampled.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic wait_cfg(input int max_cycles);
    int n = 0;
    while (configure == '0 && n < max_cycles) begin
      step();
      n++;
    end
    check("wait_cfg", 32'(configure != '0), 1);
  endtask

  // Transaction model: a queue of buffered words and the phase of the word
  // on the wire, advanced once per rising edge.
  typedef enum {M_IDLE, M_DRIVE, M_REL} mphase_t;
  mphase_t     ph = M_IDLE;
  logic [10:0] mq[$];
  logic [10:0] cur = '0;
  int          since_rel = 0;
  int          dlen = 0;
  bit          mready = 1'b0;

  always @(negedge clock) begin
    logic [10:0] e_cfg;
    bit e_sent, e_drop;
    if (!reset) begin
      mq.delete();
      ph     = M_IDLE;
      mready = 1'b0;
      check("rst_cfg",   configure,  0);
      check("rst_busy",  busy,       0);
      check("rst_sent",  sent_pulse, 0);
      check("rst_drop",  drop_pulse, 0);
      check("rst_ready", req_ready,  0);
    end else begin
      e_cfg  = '0;
      e_sent = 1'b0;
      e_drop = 1'b0;
      case (ph)
        M_DRIVE: begin
          if (processor_ready) begin
            e_sent = 1'b1; ph = M_REL; since_rel = 0;
          end else if (TO_ON && dlen == TO - 1) begin
            e_drop = 1'b1; ph = M_REL; since_rel = 0;
          end else begin
            e_cfg = cur; dlen++;
          end
        end
        M_REL: begin
          since_rel++;
          if (since_rel >= GAP && !processor_ready) ph = M_IDLE;
        end
        default: begin
          if (mq.size() > 0) begin
            cur = mq.pop_front(); e_cfg = cur; ph = M_DRIVE; dlen = 0;
          end
        end
      endcase
      if (req_valid && mready) mq.push_back(mk(req_data, req_dest));
      mready = (mq.size() < DEPTH);
      check("cfg",   configure,  32'(e_cfg));
      check("sent",  sent_pulse, 32'(e_sent));
      check("drop",  drop_pulse, 32'(e_drop));
      check("busy",  busy,       32'(mq.size() > 0 || ph != M_IDLE));
      check("ready", req_ready,  32'(mready));
      sent_cnt += int'(sent_pulse);
      drop_cnt += int'(drop_pulse);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_sent, base_drop;
    logic [1:0] dests [4];
    dests = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held with a request pending: nothing may be captured.
    reset = 1'b0; req_valid = 1'b1; req_dest = 2'd3; req_data = 8'hAA; processor_ready = 1'b0;
    repeat (3) step();
    check("src_id", src_id_o, 0);
    reset = 1'b1; req_valid = 1'b0;
    step();
    check("ready_after_rst", req_ready, 1);
    check("busy_after_rst", busy, 0);

    // Single send, accepted after five drive cycles.
    base_sent = sent_cnt;
    req_valid = 1'b1; req_dest = 2'd1; req_data = 8'h01;
    step();
    req_valid = 1'b0;
    check("single_push_edge", configure, 0);
    step();
    check("single_word", configure, 32'(11'b00000001011));
    repeat (4) step();
    check("single_held", configure, 32'(11'b00000001011));
    processor_ready = 1'b1;
    step();
    processor_ready = 1'b0;
    check("single_release", configure, 0);
    check("single_pulse", sent_pulse, 1);
    step();
    check("single_pulse_end", sent_pulse, 0);
    check("single_count", sent_cnt - base_sent, 1);

    // Sticky ready for ten edges, filling the FIFO meanwhile.
    base_sent = sent_cnt;
    req_valid = 1'b1; req_dest = 2'd2; req_data = 8'h55;
    step();
    req_valid = 1'b0;
    wait_cfg(20);
    processor_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_dest = dests[i]; req_data = 8'h11 + 8'(i);
      step();
    end
    req_valid = 1'b0;
    check("full_ready", req_ready, 0);
    check("sticky_cfg", configure, 0);
    repeat (5) step();
    check("sticky_still_zero", configure, 0);
    processor_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_cfg(20);
      check("order", configure, 32'(mk(8'h11 + 8'(k), dests[k])));
      repeat (2) step();
      processor_ready = 1'b1;
      step();
      processor_ready = 1'b0;
    end
    for (int n = 0; n < 20 && busy; n++) step();
    check("b2b_busy_fall", busy, 0);
    check("b2b_count", sent_cnt - base_sent, 5);

    // Reset while a word is on the wire, with another still queued.
    req_valid = 1'b1; req_dest = 2'd3; req_data = 8'h77;
    step();
    req_dest = 2'd0; req_data = 8'h78;
    step();
    req_valid = 1'b0;
    wait_cfg(20);
    base_sent = sent_cnt;
    base_drop = drop_cnt;
    #2 reset = 1'b0;
    #1 check("async_cfg", configure, 0);
    check("async_busy", busy, 0);
    repeat (2) step();
    reset = 1'b1;
    repeat (5) step();
    check("post_rst_cfg", configure, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_sent", sent_cnt - base_sent, 0);
    check("post_rst_drop", drop_cnt - base_drop, 0);

`ifdef NOC_TX_TIMEOUT_EN
    // The mesh never answers: both words are abandoned in turn.
    base_sent = sent_cnt;
    base_drop = drop_cnt;
    req_valid = 1'b1; req_dest = 2'd1; req_data = 8'hC1;
    step();
    req_dest = 2'd2; req_data = 8'hC2;
    step();
    req_valid = 1'b0;
    repeat (2 * (TO + GAP + 4)) step();
    check("to_drops", drop_cnt - base_drop, 2);
    check("to_no_sent", sent_cnt - base_sent, 0);
    check("to_idle", busy, 0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      req_valid       = ($urandom_range(0, 99) < 45);
      req_dest        = 2'($urandom_range(0, 3));
      req_data        = 8'($urandom);
      processor_ready = ($urandom_range(0, 99) < 30);
      step();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 400 && busy; c++) begin
      processor_ready = (configure != '0);
      step();
    end
    processor_ready = 1'b0;
    step();
    check("drain_busy", busy, 0);
    check("drain_cfg", configure, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
